// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: operand forwarding selects, load-use and memory-wait
// stalls, branch-redirect flushes, and a multi-cycle EX unit tracker.
module hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MC_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_SRC*REG_AW-1:0] de_rs,
  input  logic [NUM_SRC-1:0]        de_rs_used,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_we,
  input  logic                      ex_load,
  input  logic                      ex_mc_start,
  input  logic                      ex_redirect,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_we,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_we,
  input  logic                      dmem_ready,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_if,
  output logic                      stall_de,
  output logic                      stall_ex,
  output logic                      stall_mem,
  output logic                      bubble_ex,
  output logic                      bubble_mem,
  output logic                      flush_if_de,
  output logic                      mc_busy,
  output logic                      mc_done,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int MC_CW = $clog2(MC_LAT);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  state_t           state, next_state;
  logic [MC_CW-1:0] mc_cnt, next_cnt;

  logic load_use;
  logic mem_wait;
  logic mc_hold;
  logic mc_last;
  logic redirect_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      mc_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      state  <= next_state;
      mc_cnt <= next_cnt;
      if (stall_if && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // The down-counter only advances while memory is ready, so a data-memory wait
  // stretches the multi-cycle op instead of letting it finish under a frozen pipe.
  always_comb begin
    next_state = state;
    next_cnt   = mc_cnt;
    case (state)
      IDLE: begin
        if (ex_mc_start && !stall_ex) begin
          next_state = MC_BUSY;
          next_cnt   = MC_CW'(MC_LAT - 1);
        end
      end
      MC_BUSY: begin
        if (dmem_ready) begin
          if (mc_cnt == '0) next_state = IDLE;
          else              next_cnt   = mc_cnt - 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    logic [REG_AW-1:0] rs;
    rs          = '0;
    fwd_sel     = '0;
    load_use    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = de_rs[i*REG_AW +: REG_AW];
      if (de_rs_used[i] && (rs != '0)) begin
        if (ex_we && (ex_rd == rs) && !ex_load) fwd_sel[2*i +: 2] = 2'd1;
        else if (mem_we && (mem_rd == rs))      fwd_sel[2*i +: 2] = 2'd2;
        else if (wb_we && (wb_rd == rs))        fwd_sel[2*i +: 2] = 2'd3;
        if (ex_we && ex_load && (ex_rd == rs))  load_use = 1'b1;
      end
    end

    mem_wait    = !dmem_ready;
    mc_last     = (state == MC_BUSY) && (mc_cnt == '0);
    mc_hold     = (state == MC_BUSY) && (mc_cnt != '0);
    stall_ex    = mem_wait || mc_hold;
    redirect_ok = ex_redirect && !stall_ex;

    // A taken redirect squashes the DE instruction, so its load-use stall is moot.
    stall_if    = stall_ex || (load_use && !redirect_ok);
    stall_de    = stall_if;
    stall_mem   = mem_wait;
    bubble_ex   = !stall_ex && (load_use || redirect_ok);
    bubble_mem  = mc_hold && !mem_wait;
    flush_if_de = redirect_ok;
    mc_busy     = mc_hold;
    mc_done     = mc_last && dmem_ready;

    if (RST) begin
      fwd_sel     = '0;
      stall_if    = 1'b0;
      stall_de    = 1'b0;
      stall_ex    = 1'b0;
      stall_mem   = 1'b0;
      bubble_ex   = 1'b0;
      bubble_mem  = 1'b0;
      flush_if_de = 1'b0;
      mc_busy     = 1'b0;
      mc_done     = 1'b0;
    end
  end

endmodule
